arith_engine: RTL and testbench
===============================

Name: arith_engine

Overview:
- Parametrised successor to the fixed 4-bit adder/multiplier pair: one operand channel with a valid/ready handshake, selectable add/sub/mul, and a buffered result channel.
- Add/sub complete in a single cycle; mul runs on an iterative shift-add datapath taking WIDTH cycles.
- Results are queued in an output FIFO of DEPTH entries, so the downstream consumer can apply backpressure.
- Sits between the stimulus/driver side and any sink; replaces adder and mul instances in top-level integration.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand request valid.
- in_ready  out  1  engine accepts request this cycle.
- in_op  in  2  00 add, 01 sub, 10 mul, 11 illegal.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  2*WIDTH  result at FIFO head.
- out_op  out  2  op code of head result.
- out_err  out  1  head result came from illegal op.
- busy  out  1  multiplier FSM not IDLE.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: state=IDLE, FIFO empty, count=0, out_valid=0, busy=0, in_ready=0 during rst. out_data/out_op/out_err=0 while empty.
- Accept: a request is accepted on a clk edge with in_valid && in_ready.
- in_ready = (state==IDLE) && (count<DEPTH) && !rst.
  - Depends on registered state only; no same-cycle pop-through credit.
- Add: push {zero-extend, a+b as WIDTH+1 bits} on the accept edge. Latency 1: out_valid is high the cycle after accept if the FIFO was empty.
- Sub: push (a-b) mod 2^(WIDTH+1), zero-extended to 2*WIDTH. Bit WIDTH is the borrow/sign. Latency 1.
- Illegal op (11): accepted, pushes out_data=0, out_err=1, latency 1.
- Mul FSM states: IDLE -> MUL -> DONE -> IDLE.
  - IDLE: on mul accept, latch a and b, clear accumulator, iteration counter=0, go to MUL.
  - MUL: each cycle, if b[cnt] then acc += a<<cnt; cnt++. After WIDTH iterations go to DONE.
  - DONE: push acc, go to IDLE.
  - Total latency from accept edge to out_valid is WIDTH+1 cycles.
  - busy=1 in MUL and DONE; in_ready=0 while busy.
- FIFO slot is guaranteed: a mul is accepted only when count<DEPTH, and nothing else is accepted while busy. DONE therefore never sees a full FIFO.
- Pop: on out_ready && out_valid the head advances.
  - Simultaneous push and pop leaves count unchanged.
  - Pop when empty is ignored.
- Pointers wrap modulo DEPTH. count saturates by construction at DEPTH and never exceeds it.
- Ordering: results leave in acceptance order.
- Reset mid-operation: rst while in MUL discards the operation and flushes the FIFO. The engine returns to the reset state on the next edge.
- Input stability: in_op, in_a and in_b are sampled only on the accept edge; they are don't-care otherwise.

Decomposition:
- Package arith_engine_pkg: op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_ILL), state_e enum (IDLE, MUL, DONE), result entry struct {data, op, err}.
- Sub-module arith_fifo: parametrised synchronous FIFO of the result struct with push, pop, full, empty and count. The FSM and datapath stay in arith_engine.

Test Plan (WIDTH=4, DEPTH=4):
- Add 15+15, out_ready=1 -> next cycle out_valid=1, out_data=0x1E, out_op=00, out_err=0; count back to 0 after pop.
- Sub 2-7 -> out_data=0x1B (5-bit two's complement -5), latency 1. Sub 7-2 -> 0x05.
- Mul 15*15 accepted at edge 0:
  - busy=1 and in_ready=0 for 5 cycles.
  - out_valid at cycle 5 with out_data=0xE1; 0*9 -> 0x00.
- Backpressure: out_ready=0, issue adds 1+1, 2+2, 3+3, 4+4.
  - count=4 and in_ready=0; a fifth request is held.
  - Raise out_ready: results 2, 4, 6, 8 appear in order, then the fifth is accepted.
- Mul 3*5 then add 1+1 held valid -> add accepted only after DONE (in_ready rises 5 cycles after the mul accept); outputs appear as 0x0F then 0x02.
- rst asserted in cycle 2 of mul 9*9 -> next cycle busy=0, count=0, out_valid=0. After release, add 1+2 yields 0x03; op 11 yields out_err=1, out_data=0.

Source files
------------

// File: rtl/arith_engine_pkg.sv
// Shared types for the arithmetic engine: op codes, mul FSM states and result metadata.
package arith_engine_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_ILL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Width-independent part of a result entry; the data field is added by the
   // engine because its width follows the WIDTH parameter.
   typedef struct packed {
      op_e  op;
      logic err;
   } res_meta_t;

endpackage

// File: rtl/arith_engine_if.sv
// Operand/result handshake bundle between a driver (master) and the engine (slave).
interface arith_engine_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [1:0]               in_op;
   logic [WIDTH-1:0]         in_a;
   logic [WIDTH-1:0]         in_b;
   logic                     out_valid;
   logic                     out_ready;
   logic [2*WIDTH-1:0]       out_data;
   logic [1:0]               out_op;
   logic                     out_err;
   logic                     busy;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_op, out_err, busy, count
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_op, out_err, busy, count
   );
endinterface

// File: rtl/arith_fifo.sv
// Synchronous result FIFO; head reads as zero while empty, pop on empty is ignored.
module arith_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output T                       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? T'('0) : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/arith_engine.sv
// Add/sub/mul engine: single-cycle add/sub, iterative shift-add multiply, FIFO-buffered results.
//   state | meaning
//   IDLE  | accepting requests; add/sub/illegal push straight into the FIFO
//   MUL   | one shift-add step per cycle over bits of b, WIDTH cycles
//   DONE  | push accumulated product, return to IDLE
module arith_engine
   import arith_engine_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   arith_engine_if.slave     bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef struct packed {
      logic [2*WIDTH-1:0] data;
      res_meta_t          meta;
   } result_t;

   state_e             state, state_nxt;
   logic [WIDTH-1:0]   mul_a, mul_a_nxt;
   logic [WIDTH-1:0]   mul_b, mul_b_nxt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;

   op_e                op_in;
   logic               accept;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic               push;
   result_t            push_entry;
   result_t            head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;

   assign op_in  = op_e'(bus.in_op);
   assign sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
   assign diff   = {1'b0, bus.in_a} - {1'b0, bus.in_b};

   assign bus.in_ready = (state == IDLE) && (fifo_count < CW'(DEPTH)) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      state_nxt  = state;
      mul_a_nxt  = mul_a;
      mul_b_nxt  = mul_b;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      push       = 1'b0;
      push_entry = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               push_entry.meta.op = op_in;
               case (op_in)
                  OP_ADD: begin
                     push            = 1'b1;
                     push_entry.data = {{(WIDTH-1){1'b0}}, sum};
                  end
                  OP_SUB: begin
                     push            = 1'b1;
                     push_entry.data = {{(WIDTH-1){1'b0}}, diff};
                  end
                  OP_MUL: begin
                     mul_a_nxt = bus.in_a;
                     mul_b_nxt = bus.in_b;
                     acc_nxt   = '0;
                     cnt_nxt   = '0;
                     state_nxt = MUL;
                  end
                  default: begin
                     push                = 1'b1;
                     push_entry.meta.err = 1'b1;
                  end
               endcase
            end
         end
         MUL: begin
            if (mul_b[cnt]) begin
               acc_nxt = acc + ({{WIDTH{1'b0}}, mul_a} << cnt);
            end
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // A slot is always free here: mul needs count<DEPTH and blocks further accepts.
            push               = 1'b1;
            push_entry.data    = acc;
            push_entry.meta.op = OP_MUL;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mul_a <= '0;
         mul_b <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         mul_a <= mul_a_nxt;
         mul_b <= mul_b_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   arith_fifo #(
      .T     (result_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (bus.out_ready),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = head.data;
   assign bus.out_op    = head.meta.op;
   assign bus.out_err   = head.meta.err;
   assign bus.busy      = (state != IDLE);
   assign bus.count     = fifo_count;

   logic unused_full;
   assign unused_full = fifo_full;
endmodule

// File: tb/tb_arith_engine.sv
// Directed self-checking bench for arith_engine at WIDTH=4, DEPTH=4.
module tb_arith_engine;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   arith_engine_if #(.WIDTH(4), .DEPTH(4)) bus ();

   arith_engine #(.WIDTH(4), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'b00;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if ({bus.out_data, bus.out_op, bus.out_err} !== 11'd0) begin
         errors++; $display("FAIL reset_head got=%h/%b/%b exp=0", bus.out_data, bus.out_op, bus.out_err);
      end
      rst = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_add();
      bus.out_ready = 1'b1;
      drive(2'b00, 4'd15, 4'd15);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h1E) begin errors++; $display("FAIL add_data got=%h exp=1e", bus.out_data); end
      checks++; if (bus.out_op !== 2'b00 || bus.out_err !== 1'b0) begin
         errors++; $display("FAIL add_op_err got=%b/%b exp=00/0", bus.out_op, bus.out_err);
      end
      tick();
      checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL add_drain got count=%0d valid=%b exp=0/0", bus.count, bus.out_valid);
      end
   endtask

   task automatic test_sub();
      logic [3:0] va [2];
      logic [3:0] vb [2];
      logic [7:0] ve [2];
      va[0] = 4'd2; vb[0] = 4'd7; ve[0] = 8'h1B;
      va[1] = 4'd7; vb[1] = 4'd2; ve[1] = 8'h05;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(2'b01, va[i], vb[i]);
         tick();
         bus.in_valid = 1'b0;
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== ve[i] || bus.out_op !== 2'b01) begin
            errors++; $display("FAIL sub_%0d got valid=%b data=%h op=%b exp=1/%h/01", i, bus.out_valid, bus.out_data, bus.out_op, ve[i]);
         end
         tick();
      end
   endtask

   task automatic test_mul();
      bus.out_ready = 1'b1;
      drive(2'b10, 4'd15, 4'd15);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_busy_c%0d got busy=%b ready=%b valid=%b exp=1/0/0", i, bus.busy, bus.in_ready, bus.out_valid);
         end
         tick();
      end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE1 || bus.out_op !== 2'b10) begin
         errors++; $display("FAIL mul_15x15 got valid=%b data=%h op=%b exp=1/e1/10", bus.out_valid, bus.out_data, bus.out_op);
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_done_busy got=%b exp=0", bus.busy); end
      tick();
      drive(2'b10, 4'd0, 4'd9);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_op !== 2'b10) begin
         errors++; $display("FAIL mul_0x9 got valid=%b data=%h op=%b exp=1/00/10", bus.out_valid, bus.out_data, bus.out_op);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [5];
      logic       accepted5;
      logic       acc;
      exp[0] = 8'd2; exp[1] = 8'd4; exp[2] = 8'd6; exp[3] = 8'd8; exp[4] = 8'd10;
      accepted5     = 1'b0;
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive(2'b00, 4'(k), 4'(k));
         tick();
      end
      drive(2'b00, 4'd5, 4'd5);
      checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_full got count=%0d ready=%b exp=4/0", bus.count, bus.in_ready);
      end
      tick();
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_held got count=%0d exp=4", bus.count); end
      bus.out_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[j]) begin
            errors++; $display("FAIL bp_order_%0d got valid=%b data=%h exp=1/%h", j, bus.out_valid, bus.out_data, exp[j]);
         end
         if (j == 1) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got=%b exp=1", bus.in_ready); end
         end
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) begin
            bus.in_valid = 1'b0;
            accepted5    = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      checks++; if (accepted5 !== 1'b1 || bus.count !== 3'd0) begin
         errors++; $display("FAIL bp_fifth got accepted=%b count=%0d exp=1/0", accepted5, bus.count);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.out_ready = 1'b1;
      drive(2'b10, 4'd3, 4'd5);
      tick();
      drive(2'b00, 4'd1, 4'd1);
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL b2b_ready_delay got=%0d exp=5", n); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h0F) begin
         errors++; $display("FAIL b2b_mul got valid=%b data=%h exp=1/0f", bus.out_valid, bus.out_data);
      end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02 || bus.out_op !== 2'b00) begin
         errors++; $display("FAIL b2b_add got valid=%b data=%h op=%b exp=1/02/00", bus.out_valid, bus.out_data, bus.out_op);
      end
      tick();
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", bus.count); end
   endtask

   task automatic test_reset_mid_mul();
      bus.out_ready = 1'b0;
      drive(2'b00, 4'd4, 4'd4);
      tick();
      drive(2'b10, 4'd9, 4'd9);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.count !== 3'd1) begin
         errors++; $display("FAIL rmm_pre got busy=%b count=%0d exp=1/1", bus.busy, bus.count);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rmm_flush got busy=%b count=%0d valid=%b exp=0/0/0", bus.busy, bus.count, bus.out_valid);
      end
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      drive(2'b00, 4'd1, 4'd2);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03 || bus.out_err !== 1'b0) begin
         errors++; $display("FAIL rmm_add got valid=%b data=%h err=%b exp=1/03/0", bus.out_valid, bus.out_data, bus.out_err);
      end
      tick();
      drive(2'b11, 4'd5, 4'd6);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_data !== 8'h00 || bus.out_op !== 2'b11) begin
         errors++; $display("FAIL illegal_op got valid=%b err=%b data=%h op=%b exp=1/1/00/11", bus.out_valid, bus.out_err, bus.out_data, bus.out_op);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
